// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state, coin-code constants and coin valuation for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_A    = 2'b01;
    localparam logic [1:0] COIN_B    = 2'b10;
    localparam logic [1:0] COIN_C    = 2'b11;

    function automatic logic [31:0] coin_value(
        input logic [1:0]  code,
        input logic [31:0] val_a,
        input logic [31:0] val_b,
        input logic [31:0] val_c
    );
        case (code)
            COIN_A:  return val_a;
            COIN_B:  return val_b;
            COIN_C:  return val_c;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_unit.sv
// rtl/vend_change_unit.sv - change payout step: one pulse per cycle, credit decrement and done flag
module vend_change_unit #(
    parameter int W        = 9,
    parameter int CHG_UNIT = 5
) (
    input  logic         active,
    input  logic [W-1:0] credit,
    output logic         chg_pulse,
    output logic [W-1:0] credit_nxt,
    output logic         done
);

    localparam logic [W-1:0] CHG_W = W'(CHG_UNIT);

    assign chg_pulse  = active;
    assign credit_nxt = credit - CHG_W;
    // Leave once the remaining credit can no longer fund a whole pulse.
    assign done       = credit_nxt < CHG_W;

endmodule

// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised vending controller; VEND_CHANGE_EN enables the CHANGE/refund path
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8,
    parameter int PRICE    = 15,
    parameter int VAL_A    = 5,
    parameter int VAL_B    = 10,
    parameter int VAL_C    = 25,
    parameter int CHG_UNIT = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                vend_ready,
    output logic                vend_valid,
    output logic                chg_pulse,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int W = CREDIT_W + 1;
    localparam logic [W-1:0] CMAX    = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [W-1:0] PRICE_W = W'(PRICE);
    localparam logic [1:0]   S_COLLECT = 2'(COLLECT);
    localparam logic [1:0]   S_VEND    = 2'(VEND);

    logic [1:0]   state, state_nxt;
    logic [W-1:0] cred_q, cred_nxt;
    logic         rej_q, rej_nxt;
    logic [W-1:0] coin_val, sum, collect_cred, rem;
    logic         coin_seen, coin_ok;

    assign coin_val     = W'(coin_value(coin, VAL_A, VAL_B, VAL_C));
    assign sum          = cred_q + coin_val;
    assign coin_seen    = coin != COIN_NONE;
    assign coin_ok      = coin_seen && (sum <= CMAX);
    assign collect_cred = coin_ok ? sum : cred_q;
    assign rem          = cred_q - PRICE_W;

`ifdef VEND_CHANGE_EN
    localparam logic [1:0]   S_CHANGE = 2'(CHANGE);
    localparam logic [W-1:0] CHG_W    = W'(CHG_UNIT);
    logic [W-1:0] chg_cred;
    logic         chg_done;

    vend_change_unit #(
        .W        (W),
        .CHG_UNIT (CHG_UNIT)
    ) u_change (
        .active     (state == S_CHANGE),
        .credit     (cred_q),
        .chg_pulse  (chg_pulse),
        .credit_nxt (chg_cred),
        .done       (chg_done)
    );
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign chg_pulse     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cred_nxt  = cred_q;
        rej_nxt   = 1'b0;
        case (state)
            S_COLLECT: begin
                rej_nxt  = coin_seen && !coin_ok;
                cred_nxt = collect_cred;
                if (collect_cred >= PRICE_W)
                    state_nxt = S_VEND;
`ifdef VEND_CHANGE_EN
                else if (cancel && collect_cred >= CHG_W)
                    state_nxt = S_CHANGE;
`endif
            end
            S_VEND: begin
                rej_nxt = coin_seen;
                // Handshake has priority over a simultaneous cancel.
                if (vend_ready) begin
                    cred_nxt  = rem;
                    state_nxt = S_COLLECT;
`ifdef VEND_CHANGE_EN
                    if (rem >= CHG_W)
                        state_nxt = S_CHANGE;
`endif
                end
`ifdef VEND_CHANGE_EN
                else if (cancel)
                    state_nxt = (cred_q >= CHG_W) ? S_CHANGE : S_COLLECT;
`endif
            end
`ifdef VEND_CHANGE_EN
            S_CHANGE: begin
                rej_nxt  = coin_seen;
                cred_nxt = chg_cred;
                if (chg_done)
                    state_nxt = S_COLLECT;
            end
`endif
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_COLLECT;
            cred_q <= '0;
            rej_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cred_q <= cred_nxt;
            rej_q  <= rej_nxt;
        end
    end

    assign vend_valid = state == S_VEND;
    assign busy       = state != S_COLLECT;
    assign coin_rej   = rej_q;
    assign credit     = cred_q[CREDIT_W-1:0];

endmodule
